// File: rtl/pm_video_pkg.sv
// Shared video definitions for the Pokemon Mini display path.
// Holds the 640x400 VGA geometry also used by the timing generator, the
// LCD framebuffer size, RGB332 colour constants, the per-frame latched
// configuration record and the page-offset helper for framebuffer addressing.
package pm_video_pkg;

  // VGA 640x400 geometry: visible / front porch / sync / back porch
  localparam int unsigned VGA_H_VIS  = 640;
  localparam int unsigned VGA_H_FP   = 16;
  localparam int unsigned VGA_H_SYNC = 96;
  localparam int unsigned VGA_H_BP   = 48;
  localparam int unsigned VGA_V_VIS  = 400;
  localparam int unsigned VGA_V_FP   = 12;
  localparam int unsigned VGA_V_SYNC = 2;
  localparam int unsigned VGA_V_BP   = 35;

  // LCD panel size in pixels
  localparam int unsigned LCD_W = 96;
  localparam int unsigned LCD_H = 64;

  // RGB332 colours
  localparam logic [7:0] RGB_LCD_ON  = 8'h24;
  localparam logic [7:0] RGB_LCD_OFF = 8'hB6;
  localparam logic [7:0] RGB_BORDER  = 8'h00;

  // Configuration captured once per frame
  typedef struct packed {
    logic [23:0] base;
    logic        en;
    logic        inv;
  } frame_cfg_t;

  // page * 96 built from two shifts so no multiplier is inferred
  function automatic logic [23:0] page_offset(input logic [2:0] page);
    logic [23:0] p;
    p = {21'd0, page};
    return (p << 6) + (p << 5);
  endfunction

endpackage

// File: rtl/pm_scale_counter.sv
// Replication divider plus index counter.
// A sub-counter counts SCALE steps; each time it wraps, the index advances.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : forces sub-counter and index to 0 (has priority)
//   step_i        : advance by one replicated sample
//   idx_o         : current index (source pixel / row)
module pm_scale_counter #(
  parameter int unsigned SCALE = 6,
  parameter int unsigned IDX_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             step_i,
  output logic [IDX_W-1:0] idx_o
);

  localparam int unsigned      SUB_W    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);

  logic [SUB_W-1:0] sub_q, sub_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    sub_d = sub_q;
    idx_d = idx_q;
    if (clr_i) begin
      sub_d = '0;
      idx_d = '0;
    end else if (step_i) begin
      if (sub_q == SUB_LAST) begin
        sub_d = '0;
        idx_d = idx_q + IDX_W'(1);
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sub_q <= '0;
      idx_q <= '0;
    end else begin
      sub_q <= sub_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/pm_lcd_scanout.sv
// Framebuffer scanout: reads the 96x64 monochrome LCD image from RAM and
// scales it SCALE x into a window of the VGA raster, producing RGB332 pixels.
// Ports:
//   pclk, reset_n           : pixel clock, asynchronous active-low reset
//   h_cnt, v_cnt            : raster position from the timing generator
//   fb_base, lcd_enable,
//   lcd_invert              : configuration, captured at frame start
//   rd_en, rd_addr, rd_data : synchronous RAM read port (data one cycle later)
//   pixel, de_out           : colour and data enable, two cycles after h/v
//   frame_start             : one-cycle pulse when the configuration is loaded
module pm_lcd_scanout
  import pm_video_pkg::*;
#(
  parameter int unsigned H_VIS        = VGA_H_VIS,
  parameter int unsigned V_VIS        = VGA_V_VIS,
  parameter int unsigned SCALE        = 6,
  parameter int unsigned H_OFF        = 32,
  parameter int unsigned V_OFF        = 8,
  parameter logic [23:0] FB_BASE      = 24'h001000,
  parameter logic [7:0]  COLOR_ON     = RGB_LCD_ON,
  parameter logic [7:0]  COLOR_OFF    = RGB_LCD_OFF,
  parameter logic [7:0]  COLOR_BORDER = RGB_BORDER
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic [23:0] fb_base,
  input  logic        lcd_enable,
  input  logic        lcd_invert,
  output logic        rd_en,
  output logic [23:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic [7:0]  pixel,
  output logic        de_out,
  output logic        frame_start
);

  localparam logic [9:0] H_WIN_LO = 10'(H_OFF);
  localparam logic [9:0] H_WIN_HI = 10'(H_OFF + SCALE * LCD_W);
  localparam logic [9:0] V_WIN_LO = 10'(V_OFF);
  localparam logic [9:0] V_WIN_HI = 10'(V_OFF + SCALE * LCD_H);
  localparam logic [9:0] H_LAST   = 10'(H_VIS - 1);
  localparam logic [9:0] H_END    = 10'(H_VIS);
  localparam logic [9:0] V_END    = 10'(V_VIS);

  logic       h_win, v_win, frame_evt, line_end;
  logic [6:0] col;
  logic [5:0] row;

  frame_cfg_t cfg_q, cfg_d;
  logic       win_d1_q, win_d1_d;
  logic       de_d1_q, de_d1_d;
  logic [2:0] bsel_d1_q, bsel_d1_d;
  logic [7:0] pixel_q, pixel_d;
  logic       de_q, de_d;
  logic       fs_q, fs_d;

  assign h_win     = (h_cnt >= H_WIN_LO) && (h_cnt < H_WIN_HI);
  assign v_win     = (v_cnt >= V_WIN_LO) && (v_cnt < V_WIN_HI);
  assign frame_evt = (v_cnt == V_END) && (h_cnt == '0);
  assign line_end  = (h_cnt == H_LAST);

  // col leaves the window at 96 and is brought back to 0 by the clear only
  pm_scale_counter #(.SCALE(SCALE), .IDX_W(7)) u_hcnt (
    .clk_i  (pclk),
    .rst_ni (reset_n),
    .clr_i  (!h_win),
    .step_i (h_win),
    .idx_o  (col)
  );

  pm_scale_counter #(.SCALE(SCALE), .IDX_W(6)) u_vcnt (
    .clk_i  (pclk),
    .rst_ni (reset_n),
    .clr_i  (!v_win),
    .step_i (line_end && v_win),
    .idx_o  (row)
  );

  // S0: address from registered counters, which track the current h/v
  assign rd_en   = h_win && v_win && cfg_q.en;
  assign rd_addr = cfg_q.base + page_offset(row[5:3]) + {17'd0, col};

  always_comb begin
    cfg_d     = cfg_q;
    win_d1_d  = h_win && v_win;
    de_d1_d   = (h_cnt < H_END) && (v_cnt < V_END);
    bsel_d1_d = row[2:0];
    de_d      = de_d1_q;
    fs_d      = frame_evt;
    pixel_d   = COLOR_BORDER;
    if (frame_evt) begin
      cfg_d = '{base: fb_base, en: lcd_enable, inv: lcd_invert};
    end
    // S1 bit select feeds the S2 colour register directly
    if (!win_d1_q) begin
      pixel_d = COLOR_BORDER;
    end else if (!cfg_q.en) begin
      pixel_d = COLOR_OFF;
    end else if (rd_data[bsel_d1_q] ^ cfg_q.inv) begin
      pixel_d = COLOR_ON;
    end else begin
      pixel_d = COLOR_OFF;
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q     <= '{base: FB_BASE, en: 1'b1, inv: 1'b0};
      win_d1_q  <= 1'b0;
      de_d1_q   <= 1'b0;
      bsel_d1_q <= '0;
      pixel_q   <= '0;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      win_d1_q  <= win_d1_d;
      de_d1_q   <= de_d1_d;
      bsel_d1_q <= bsel_d1_d;
      pixel_q   <= pixel_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
    end
  end

  assign pixel       = pixel_q;
  assign de_out      = de_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_pm_lcd_scanout.sv
// Bench for pm_lcd_scanout: drives a compressed raster (most lines reduced to
// a few out-of-window positions plus the line-end column, selected lines
// scanned in full) and compares every cycle against a coordinate-based model.
module tb_pm_lcd_scanout;

  logic        pclk = 1'b0;
  logic        reset_n;
  logic [9:0]  h_cnt, v_cnt;
  logic [23:0] fb_base;
  logic        lcd_enable, lcd_invert;
  logic        rd_en;
  logic [23:0] rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  pixel;
  logic        de_out, frame_start;

  pm_lcd_scanout #(
    .SCALE   (6),
    .H_OFF   (32),
    .V_OFF   (8),
    .FB_BASE (24'h001000)
  ) dut (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .fb_base     (fb_base),
    .lcd_enable  (lcd_enable),
    .lcd_invert  (lcd_invert),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .pixel       (pixel),
    .de_out      (de_out),
    .frame_start (frame_start)
  );

  always #5 pclk = ~pclk;

  // Synchronous RAM: data one cycle after the strobe
  logic [7:0] mem [0:65535];
  always @(posedge pclk) if (rd_en) rd_data <= mem[rd_addr[15:0]];

  typedef struct {
    logic        rd_en;
    logic        addr_chk;
    logic [23:0] addr;
    logic        pix_chk;
    logic [7:0]  pix;
    logic        de;
    logic        fs;
    logic        win;
    int          h;
    int          v;
    int          frame;
  } exp_t;

  exp_t d0, d1, d2;           // expectations for the last three applied vectors
  logic [23:0] m_base;
  logic        m_en, m_inv;
  bit          img_ok;
  int          m_frame;
  int          n_vec, n_chk, n_err;
  bit          started, rst_hold;
  bit          full [0:448];

  function automatic exp_t reset_entry();
    exp_t e;
    e = '{default: 0};
    e.pix_chk = 1'b1;
    e.h = -1;
    e.v = -1;
    return e;
  endfunction

  task automatic model_reset();
    m_base = 24'h001000;
    m_en   = 1'b1;
    m_inv  = 1'b0;
    img_ok = 1'b0;
    d0 = reset_entry();
    d1 = reset_entry();
    d2 = reset_entry();
  endtask

  // Expected behaviour from raster coordinates alone
  task automatic model(input int h, input int v, output exp_t e);
    bit hw, vw;
    int x, y;
    logic [23:0] a;
    logic b;
    e = '{default: 0};
    hw = (h >= 32) && (h < 32 + 6*96);
    vw = (v >= 8) && (v < 8 + 6*64);
    x = (h - 32) / 6;
    y = (v - 8) / 6;
    b = 1'b0;
    a = '0;
    if (hw && vw) begin
      a = 24'(m_base + (y / 8) * 96 + x);
      b = mem[a[15:0]][y % 8];
    end
    e.h = h; e.v = v; e.frame = m_frame;
    e.win      = hw && vw;
    e.rd_en    = hw && vw && m_en;
    e.addr     = a;
    e.addr_chk = e.rd_en && img_ok;
    e.pix      = !(hw && vw) ? 8'h00 : (!m_en ? 8'hB6 : ((b ^ m_inv) ? 8'h24 : 8'hB6));
    e.pix_chk  = !(hw && vw) || img_ok;
    e.de       = (h < 640) && (v < 400);
    e.fs       = (v == 400) && (h == 0);
    if (e.fs) begin
      m_base  = fb_base;
      m_en    = lcd_enable;
      m_inv   = lcd_invert;
      img_ok  = 1'b1;
      m_frame = m_frame + 1;
    end
  endtask

  task automatic cycle(input int h, input int v);
    exp_t e;
    @(posedge pclk);
    #1;
    if (rst_hold) begin
      if (reset_n) begin
        reset_n = 1'b0;
        model_reset();
      end
    end else begin
      reset_n = 1'b1;
    end
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    n_vec++;
    if (!reset_n) e = reset_entry();
    else model(h, v, e);
    d2 = d1;
    d1 = d0;
    d0 = e;
  endtask

  function automatic int pick_h();
    int r;
    if ($urandom_range(0, 1) == 0) r = $urandom_range(1, 31);
    else begin
      r = $urandom_range(608, 1023);
      if (r == 639) r = 640;
    end
    return r;
  endfunction

  task automatic run_lines(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) begin
      if (full[v]) begin
        for (int h = 0; h <= 645; h++) cycle(h, v);
      end else begin
        cycle(0, v);
        cycle(pick_h(), v);
        cycle(639, v);
      end
    end
  endtask

  task automatic set_full(input int pct);
    for (int v = 0; v <= 448; v++)
      full[v] = (v >= 8) && (v < 392) && ($urandom_range(0, 99) < pct);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp,
                     input int h, input int v);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (h=%0d v=%0d): got %0h, expected %0h", nm, h, v, act, exp);
    end
  endtask

  // Single compare process, mid-cycle
  always @(negedge pclk) begin
    if (started) begin
      chk("rd_en", 32'(rd_en), 32'(d0.rd_en), d0.h, d0.v);
      if (d0.addr_chk) chk("rd_addr", 32'(rd_addr), 32'(d0.addr), d0.h, d0.v);
      if (d2.pix_chk) chk("pixel", 32'(pixel), 32'(d2.pix), d2.h, d2.v);
      chk("de_out", 32'(de_out), 32'(d2.de), d2.h, d2.v);
      chk("frame_start", 32'(frame_start), 32'(d1.fs), d1.h, d1.v);
      // hand-computed anchors
      if (d0.h == 32 && d0.v == 8 && d0.frame == 1)
        chk("first_addr", 32'(rd_addr), 32'h001000, d0.h, d0.v);
      if (d0.h == 32 && d0.v == 8 && d0.frame == 2)
        chk("rebased_addr", 32'(rd_addr), 32'h002000, d0.h, d0.v);
      if (d0.frame == 3) chk("blank_no_read", 32'(rd_en), 32'h0, d0.h, d0.v);
      if (d2.frame == 1) begin
        if (d2.v == 8 && d2.h >= 32 && d2.h <= 37)
          chk("first_px", 32'(pixel), 32'h24, d2.h, d2.v);
        if (d2.v == 8 && d2.h == 38)
          chk("second_px", 32'(pixel), 32'hB6, d2.h, d2.v);
        if (d2.v >= 386 && d2.v <= 391 && d2.h >= 602 && d2.h <= 607)
          chk("last_byte", 32'(pixel), 32'h24, d2.h, d2.v);
        if (d2.v < 400 && d2.h >= 0 && d2.h < 32) begin
          chk("border_px", 32'(pixel), 32'h00, d2.h, d2.v);
          chk("border_de", 32'(de_out), 32'h1, d2.h, d2.v);
        end
        if (d2.h == 640) chk("de_end", 32'(de_out), 32'h0, d2.h, d2.v);
      end
      if (d2.frame == 3 && d2.win) chk("blank_px", 32'(pixel), 32'hB6, d2.h, d2.v);
      if (d2.frame == 4 && d2.win) chk("invert_px", 32'(pixel), 32'h24, d2.h, d2.v);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_chk = 0; n_err = 0; m_frame = 0;
    started = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 16'h2000; i < 16'h2300; i++) mem[i] = 8'($urandom);
    mem[16'h1000] = 8'h01;
    mem[16'h12FF] = 8'h80;
    reset_n = 1'b0; h_cnt = 10'd5; v_cnt = 10'd0;
    fb_base = 24'h001000; lcd_enable = 1'b1; lcd_invert = 1'b0;
    model_reset();
    rst_hold = 1'b1;
    repeat (3) cycle(5, 0);
    started  = 1'b1;
    rst_hold = 1'b0;

    // enter at the frame-start line so frame 1 is complete
    for (int v = 0; v <= 448; v++) full[v] = 1'b0;
    run_lines(400, 448);

    // frame 1: directed image, base change mid-frame takes effect next frame
    set_full(2);
    full[0] = 1'b1; full[8] = 1'b1; full[9] = 1'b1; full[386] = 1'b1; full[391] = 1'b1;
    run_lines(0, 199);
    fb_base = 24'h002000;
    run_lines(200, 448);

    // frame 2: random image at 0x2000
    set_full(5);
    run_lines(0, 150);
    lcd_enable = 1'b0;
    run_lines(151, 448);

    // frame 3: blanked
    set_full(3);
    run_lines(0, 150);
    lcd_enable = 1'b1; lcd_invert = 1'b1; fb_base = 24'h003000;
    run_lines(151, 448);

    // frame 4: inverted all-zero RAM
    set_full(3);
    run_lines(0, 150);
    lcd_invert = 1'($urandom); fb_base = 24'h002000;
    run_lines(151, 448);

    // frame 5: reset in the middle
    set_full(3);
    run_lines(0, 199);
    rst_hold = 1'b1;
    repeat (4) cycle(0, 200);
    rst_hold = 1'b0;
    run_lines(200, 448);

    // frame 6: first full frame after reset
    set_full(5);
    run_lines(0, 448);
    repeat (3) cycle(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
